tlb_lookup: RTL and testbench

Translation responder for mapped segments: accepts requests whose address falls in useg/kseg2/kseg3 (the `using_tlb` case of the address-map stage) and returns a physical address or a TLB exception indication. It holds a fully associative, MIPS32-style joint TLB of even/odd page pairs with fixed 4 KB pages. Software writes entries via a TLBWI-style write port. The block sits between the address-map stage and the memory/exception logic in the MMU.

---
 rtl/tlb_lookup.sv | 217 +++++++++++++++++++++
 tb/tb_tlb_lookup.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_lookup.sv
// Fully associative MIPS32-style joint TLB (even/odd 4 KB page pairs) with a TLBWI write port
// and a three-state IDLE/COMPARE/RESP lookup. Optional TLBP-style probe: define TLB_PROBE_EN.
module tlb_lookup #(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic [31:0]      vaddr_i,
    input  logic             store_i,
    input  logic [7:0]       asid_i,
    output logic             ack_o,
    output logic [31:0]      paddr_o,
    output logic             miss_o,
    output logic             invalid_o,
    output logic             modified_o,
    output logic             busy_o,
`ifdef TLB_PROBE_EN
    input  logic             probe_i,
    input  logic [31:0]      probe_hi_i,
    output logic             probe_done_o,
    output logic [31:0]      probe_index_o,
`endif
    input  logic             we_i,
    input  logic [IDX_W-1:0] windex_i,
    input  logic [31:0]      wentry_hi_i,
    input  logic [31:0]      wentry_lo0_i,
    input  logic [31:0]      wentry_lo1_i
);

    typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_RESP, S_PROBE} state_e;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic        d1;
        logic        v1;
    } entry_t;

    state_e            state_q, state_d;
    entry_t            tlb_q [NUM_ENTRIES];
    entry_t            tlb_d [NUM_ENTRIES];
    logic [31:0]       req_vaddr_q, req_vaddr_d;
    logic              req_store_q, req_store_d;
    logic [7:0]        req_asid_q, req_asid_d;
    logic [31:0]       paddr_q, paddr_d;
    logic              miss_q, miss_d;
    logic              invalid_q, invalid_d;
    logic              modified_q, modified_d;
    logic              busy_q, busy_d;

    logic [18:0]       key_vpn2;
    logic [7:0]        key_asid;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    entry_t            hit_e;
    logic [19:0]       sel_pfn;
    logic              sel_v;
    logic              sel_d;
    logic              unused_bits;

`ifdef TLB_PROBE_EN
    logic [31:0]       probe_hi_q, probe_hi_d;
    logic              probe_done_q, probe_done_d;
    logic [31:0]       probe_index_q, probe_index_d;

    assign unused_bits = ^{wentry_hi_i[12:8], wentry_lo0_i[31:26], wentry_lo0_i[5:3],
                           wentry_lo1_i[31:26], wentry_lo1_i[5:3], probe_hi_q[12:8]};
`else
    assign unused_bits = ^{wentry_hi_i[12:8], wentry_lo0_i[31:26], wentry_lo0_i[5:3],
                           wentry_lo1_i[31:26], wentry_lo1_i[5:3]};
`endif

    // The single comparator array serves both lookups and probes.
    always_comb begin
        key_vpn2 = req_vaddr_q[31:13];
        key_asid = req_asid_q;
`ifdef TLB_PROBE_EN
        if (state_q == S_PROBE) begin
            key_vpn2 = probe_hi_q[31:13];
            key_asid = probe_hi_q[7:0];
        end
`endif
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (tlb_q[i].vpn2 == key_vpn2 && (tlb_q[i].g || tlb_q[i].asid == key_asid)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        hit_e   = tlb_q[hit_idx];
        sel_pfn = req_vaddr_q[12] ? hit_e.pfn1 : hit_e.pfn0;
        sel_v   = req_vaddr_q[12] ? hit_e.v1   : hit_e.v0;
        sel_d   = req_vaddr_q[12] ? hit_e.d1   : hit_e.d0;
    end

    always_comb begin
        tlb_d = tlb_q;
        if (state_q == S_IDLE && we_i) begin
            tlb_d[windex_i] = '{vpn2: wentry_hi_i[31:13], asid: wentry_hi_i[7:0],
                                g: wentry_lo0_i[0] & wentry_lo1_i[0],
                                pfn0: wentry_lo0_i[25:6], d0: wentry_lo0_i[2], v0: wentry_lo0_i[1],
                                pfn1: wentry_lo1_i[25:6], d1: wentry_lo1_i[2], v1: wentry_lo1_i[1]};
        end
    end

    always_comb begin
        state_d     = state_q;
        req_vaddr_d = req_vaddr_q;
        req_store_d = req_store_q;
        req_asid_d  = req_asid_q;
        paddr_d     = paddr_q;
        miss_d      = miss_q;
        invalid_d   = invalid_q;
        modified_d  = modified_q;
`ifdef TLB_PROBE_EN
        probe_hi_d    = probe_hi_q;
        probe_done_d  = 1'b0;
        probe_index_d = probe_index_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (we_i) begin
                    state_d = S_IDLE;
                end
`ifdef TLB_PROBE_EN
                else if (probe_i) begin
                    probe_hi_d = probe_hi_i;
                    state_d    = S_PROBE;
                end
`endif
                else if (req_i) begin
                    req_vaddr_d = vaddr_i;
                    req_store_d = store_i;
                    req_asid_d  = asid_i;
                    state_d     = S_COMPARE;
                end
            end
            S_COMPARE: begin
                paddr_d    = '0;
                miss_d     = 1'b0;
                invalid_d  = 1'b0;
                modified_d = 1'b0;
                if (!hit)                     miss_d     = 1'b1;
                else if (!sel_v)              invalid_d  = 1'b1;
                else if (req_store_q && !sel_d) modified_d = 1'b1;
                else                          paddr_d    = {sel_pfn, req_vaddr_q[11:0]};
                state_d = S_RESP;
            end
            S_RESP: state_d = S_IDLE;
`ifdef TLB_PROBE_EN
            S_PROBE: begin
                probe_index_d = hit ? {{(32-IDX_W){1'b0}}, hit_idx} : 32'h8000_0000;
                probe_done_d  = 1'b1;
                state_d       = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_vaddr_q <= '0;
            req_store_q <= 1'b0;
            req_asid_q  <= '0;
            paddr_q     <= '0;
            miss_q      <= 1'b0;
            invalid_q   <= 1'b0;
            modified_q  <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < NUM_ENTRIES; i++) tlb_q[i] <= '0;
`ifdef TLB_PROBE_EN
            probe_hi_q    <= '0;
            probe_done_q  <= 1'b0;
            probe_index_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_vaddr_q <= req_vaddr_d;
            req_store_q <= req_store_d;
            req_asid_q  <= req_asid_d;
            paddr_q     <= paddr_d;
            miss_q      <= miss_d;
            invalid_q   <= invalid_d;
            modified_q  <= modified_d;
            busy_q      <= busy_d;
            tlb_q       <= tlb_d;
`ifdef TLB_PROBE_EN
            probe_hi_q    <= probe_hi_d;
            probe_done_q  <= probe_done_d;
            probe_index_q <= probe_index_d;
`endif
        end
    end

    assign ack_o      = (state_q == S_RESP);
    assign paddr_o    = paddr_q;
    assign miss_o     = miss_q;
    assign invalid_o  = invalid_q;
    assign modified_o = modified_q;
    assign busy_o     = busy_q;
`ifdef TLB_PROBE_EN
    assign probe_done_o  = probe_done_q;
    assign probe_index_o = probe_index_q;
`endif

endmodule

// File: tb/tb_tlb_lookup.sv
// Scoreboard bench for tlb_lookup: expected lookup results are queued at request time
// and compared on each ack. Probe scenarios are compiled in when TLB_PROBE_EN is defined.
module tb_tlb_lookup;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic [31:0] vaddr_i;
    logic        store_i;
    logic [7:0]  asid_i;
    logic        ack_o;
    logic [31:0] paddr_o;
    logic        miss_o, invalid_o, modified_o, busy_o;
    logic        we_i;
    logic [3:0]  windex_i;
    logic [31:0] wentry_hi_i, wentry_lo0_i, wentry_lo1_i;
`ifdef TLB_PROBE_EN
    logic        probe_i;
    logic [31:0] probe_hi_i;
    logic        probe_done_o;
    logic [31:0] probe_index_o;
`endif

    typedef struct {
        logic [31:0] paddr;
        logic        miss;
        logic        invalid;
        logic        modified;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    tlb_lookup #(.NUM_ENTRIES(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .vaddr_i(vaddr_i), .store_i(store_i),
        .asid_i(asid_i), .ack_o(ack_o), .paddr_o(paddr_o), .miss_o(miss_o),
        .invalid_o(invalid_o), .modified_o(modified_o), .busy_o(busy_o),
`ifdef TLB_PROBE_EN
        .probe_i(probe_i), .probe_hi_i(probe_hi_i), .probe_done_o(probe_done_o),
        .probe_index_o(probe_index_o),
`endif
        .we_i(we_i), .windex_i(windex_i), .wentry_hi_i(wentry_hi_i),
        .wentry_lo0_i(wentry_lo0_i), .wentry_lo1_i(wentry_lo1_i)
    );

    function automatic logic [31:0] mk_lo(input logic [19:0] pfn, input logic d,
                                          input logic v, input logic g);
        return {6'b0, pfn, 3'b0, d, v, g};
    endfunction

    task automatic push_exp(input logic [31:0] p, input logic m, input logic i, input logic md);
        exp_t e;
        e.paddr = p; e.miss = m; e.invalid = i; e.modified = md;
        exp_q.push_back(e);
    endtask

    task automatic write_entry(input logic [3:0] idx, input logic [31:0] hi,
                               input logic [31:0] lo0, input logic [31:0] lo1);
        we_i = 1'b1; windex_i = idx; wentry_hi_i = hi; wentry_lo0_i = lo0; wentry_lo1_i = lo1;
        @(posedge clk); #1;
        we_i = 1'b0;
    endtask

    // Issues one request, waits for ack, checks latency and the scoreboard head.
    task automatic run_req(input string name, input logic [31:0] va, input logic st,
                           input logic [7:0] asid, input logic [31:0] ep, input logic em,
                           input logic ei, input logic emod);
        exp_t e;
        int   cyc = 0;
        bit   got = 0;
        push_exp(ep, em, ei, emod);
        vaddr_i = va; store_i = st; asid_i = asid; req_i = 1'b1;
        while (cyc < 10 && !got) begin
            @(posedge clk); #1; cyc++;
            if (ack_o) got = 1;
        end
        req_i = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            failures++; $display("FAIL %s ack timeout: got no ack, required ack within 10 cycles", name);
        end else begin
            checks++;
            if (cyc !== 2) begin failures++; $display("FAIL %s latency: got %0d required 2", name, cyc); end
            checks++;
            if (paddr_o !== e.paddr) begin
                failures++; $display("FAIL %s paddr: got %h required %h", name, paddr_o, e.paddr);
            end
            checks++;
            if ({miss_o, invalid_o, modified_o} !== {e.miss, e.invalid, e.modified}) begin
                failures++;
                $display("FAIL %s flags(m,i,mod): got %b required %b", name,
                         {miss_o, invalid_o, modified_o}, {e.miss, e.invalid, e.modified});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({ack_o, miss_o, invalid_o, modified_o, busy_o} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl: got %b required 00000",
                                 {ack_o, miss_o, invalid_o, modified_o, busy_o});
        end
        checks++;
        if (paddr_o !== 32'h0) begin failures++; $display("FAIL reset_paddr: got %h required 0", paddr_o); end
`ifdef TLB_PROBE_EN
        checks++;
        if (probe_done_o !== 1'b0 || probe_index_o !== 32'h0) begin
            failures++; $display("FAIL reset_probe: got %b/%h required 0/0", probe_done_o, probe_index_o);
        end
`endif
    endtask

    task automatic test_miss();
        run_req("empty_miss", 32'h0040_1234, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_hit_invalid();
        write_entry(4'd3, 32'h0040_0005, mk_lo(20'h12345, 1'b1, 1'b1, 1'b0), mk_lo(20'h0, 1'b0, 1'b0, 1'b0));
        run_req("hit_even", 32'h0040_0ABC, 1'b0, 8'd5, 32'h1234_5ABC, 1'b0, 1'b0, 1'b0);
        run_req("odd_invalid", 32'h0040_1ABC, 1'b0, 8'd5, 32'h0, 1'b0, 1'b1, 1'b0);
        run_req("asid_miss", 32'h0040_0ABC, 1'b0, 8'd6, 32'h0, 1'b1, 1'b0, 1'b0);
        run_req("store_dirty_ok", 32'h0040_0010, 1'b1, 8'd5, 32'h1234_5010, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_modified();
        write_entry(4'd3, 32'h0040_0005, mk_lo(20'h12345, 1'b0, 1'b1, 1'b0), mk_lo(20'h0, 1'b0, 1'b0, 1'b0));
        run_req("store_modified", 32'h0040_0010, 1'b1, 8'd5, 32'h0, 1'b0, 1'b0, 1'b1);
        run_req("load_clean", 32'h0040_0010, 1'b0, 8'd5, 32'h1234_5010, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_global();
        write_entry(4'd5, 32'h0080_0011, mk_lo(20'hABCDE, 1'b1, 1'b1, 1'b1), mk_lo(20'h0BEEF, 1'b1, 1'b1, 1'b1));
        run_req("global_hit", 32'h0080_0123, 1'b0, 8'h77, 32'hABCD_E123, 1'b0, 1'b0, 1'b0);
        run_req("global_odd", 32'h0080_1FFF, 1'b0, 8'h01, 32'h0BEE_FFFF, 1'b0, 1'b0, 1'b0);
        write_entry(4'd6, 32'h00C0_0011, mk_lo(20'h22222, 1'b1, 1'b1, 1'b1), mk_lo(20'h33333, 1'b1, 1'b1, 1'b0));
        run_req("half_global_miss", 32'h00C0_0123, 1'b0, 8'h77, 32'h0, 1'b1, 1'b0, 1'b0);
        run_req("half_global_asid", 32'h00C0_0123, 1'b0, 8'h11, 32'h2222_2123, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_duplicate();
        write_entry(4'd7, 32'h0100_0022, mk_lo(20'h77777, 1'b1, 1'b1, 1'b0), mk_lo(20'h0, 1'b0, 1'b0, 1'b0));
        write_entry(4'd1, 32'h0100_0022, mk_lo(20'h11111, 1'b1, 1'b1, 1'b0), mk_lo(20'h0, 1'b0, 1'b0, 1'b0));
        run_req("dup_lowest", 32'h0100_0456, 1'b0, 8'h22, 32'h1111_1456, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_we_with_req();
        exp_t e;
        int   cyc = 0;
        bit   got = 0;
        push_exp(32'h5555_5789, 1'b0, 1'b0, 1'b0);
        we_i = 1'b1; windex_i = 4'd9; wentry_hi_i = 32'h0140_0003;
        wentry_lo0_i = mk_lo(20'h55555, 1'b1, 1'b1, 1'b0); wentry_lo1_i = 32'h0;
        vaddr_i = 32'h0140_0789; store_i = 1'b0; asid_i = 8'd3; req_i = 1'b1;
        while (cyc < 10 && !got) begin
            @(posedge clk); #1; cyc++;
            we_i = 1'b0;
            if (ack_o) got = 1;
        end
        req_i = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!got || cyc !== 3) begin
            failures++; $display("FAIL we_req_latency: got ack=%0d after %0d required ack after 3", got, cyc);
        end
        checks++;
        if (paddr_o !== e.paddr || miss_o !== e.miss) begin
            failures++; $display("FAIL we_req_paddr: got %h miss=%b required %h miss=%b",
                                 paddr_o, miss_o, e.paddr, e.miss);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_we_busy();
        vaddr_i = 32'h0040_0ABC; store_i = 1'b0; asid_i = 8'd5; req_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy_o !== 1'b1) begin failures++; $display("FAIL busy_compare: got %b required 1", busy_o); end
        we_i = 1'b1; windex_i = 4'd3; wentry_hi_i = 32'h0040_0005;
        wentry_lo0_i = mk_lo(20'h99999, 1'b1, 1'b1, 1'b0); wentry_lo1_i = 32'h0;
        @(posedge clk); #1;
        we_i = 1'b0; req_i = 1'b0;
        checks++;
        if (ack_o !== 1'b1 || paddr_o !== 32'h1234_5ABC) begin
            failures++; $display("FAIL inflight_result: got ack=%b %h required ack=1 12345abc", ack_o, paddr_o);
        end
        @(posedge clk); #1;
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL busy_idle: got %b required 0", busy_o); end
        run_req("we_busy_ignored", 32'h0040_0ABC, 1'b0, 8'd5, 32'h1234_5ABC, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vas [3];
        exp_t        e;
        int          acks = 0;
        int          cyc = 0;
        int          last = 0;
        vas[0] = 32'h0040_0001; vas[1] = 32'h0100_0002; vas[2] = 32'h0200_0003;
        push_exp(32'h1234_5001, 1'b0, 1'b0, 1'b0);
        push_exp(32'h0, 1'b1, 1'b0, 1'b0);
        push_exp(32'h0, 1'b1, 1'b0, 1'b0);
        vaddr_i = vas[0]; store_i = 1'b0; asid_i = 8'd5; req_i = 1'b1;
        while (acks < 3 && cyc < 30) begin
            @(posedge clk); #1; cyc++;
            if (ack_o) begin
                e = exp_q.pop_front();
                checks++;
                if (cyc - last !== (acks == 0 ? 2 : 3)) begin
                    failures++; $display("FAIL b2b_spacing%0d: got %0d required %0d", acks, cyc - last,
                                         acks == 0 ? 2 : 3);
                end
                checks++;
                if (paddr_o !== e.paddr || miss_o !== e.miss) begin
                    failures++; $display("FAIL b2b_result%0d: got %h miss=%b required %h miss=%b",
                                         acks, paddr_o, miss_o, e.paddr, e.miss);
                end
                last = cyc;
                acks++;
                if (acks < 3) vaddr_i = vas[acks];
                else req_i = 1'b0;
            end
        end
        req_i = 1'b0;
        checks++;
        if (acks !== 3) begin failures++; $display("FAIL b2b_count: got %0d acks required 3", acks); end
        exp_q.delete();
        @(posedge clk); #1;
    endtask

`ifdef TLB_PROBE_EN
    task automatic run_probe(input string name, input logic [31:0] hi, input logic [31:0] eidx);
        int cyc = 0;
        bit got = 0;
        probe_i = 1'b1; probe_hi_i = hi;
        while (cyc < 10 && !got) begin
            @(posedge clk); #1; cyc++;
            probe_i = 1'b0;
            if (probe_done_o) got = 1;
        end
        checks++;
        if (!got || cyc !== 2) begin
            failures++; $display("FAIL %s done: got done=%0d after %0d required after 2", name, got, cyc);
        end
        checks++;
        if (probe_index_o !== eidx) begin
            failures++; $display("FAIL %s index: got %h required %h", name, probe_index_o, eidx);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_probe();
        run_probe("probe_hit", 32'h0040_0005, 32'd3);
        run_probe("probe_miss", 32'h0FF0_0005, 32'h8000_0000);
        run_probe("probe_dup", 32'h0100_0022, 32'd1);
    endtask

    task automatic test_probe_reset();
        bit seen = 0;
        probe_i = 1'b1; probe_hi_i = 32'h0040_0005;
        @(posedge clk); #1;
        probe_i = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (probe_done_o) seen = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL probe_rst_abort: got probe_done=1 required 0"); end
    endtask
`endif

    task automatic test_reset_abort();
        bit seen = 0;
        vaddr_i = 32'h0040_0ABC; asid_i = 8'd5; store_i = 1'b0; req_i = 1'b1;
        @(posedge clk); #1;
        req_i = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (ack_o) seen = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen || busy_o !== 1'b0) begin
            failures++; $display("FAIL rst_abort: got ack_seen=%0d busy=%b required 0/0", seen, busy_o);
        end
        run_req("after_rst_cleared", 32'h0040_0ABC, 1'b0, 8'd5, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; req_i = 1'b0; vaddr_i = '0; store_i = 1'b0; asid_i = '0;
        we_i = 1'b0; windex_i = '0; wentry_hi_i = '0; wentry_lo0_i = '0; wentry_lo1_i = '0;
`ifdef TLB_PROBE_EN
        probe_i = 1'b0; probe_hi_i = '0;
`endif
        test_reset();
        test_miss();
        test_hit_invalid();
        test_modified();
        test_global();
        test_duplicate();
        test_we_with_req();
        test_we_busy();
        test_back_to_back();
`ifdef TLB_PROBE_EN
        test_probe();
        test_probe_reset();
`endif
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
